// File: rtl/tmds_rx_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tmds_rx_decode
//  Purpose  : Per-channel TMDS receive decoder. Searches for word alignment by
//             pulsing bitslip until a run of control tokens is seen, then
//             decodes 10b words into 8b pixel data or c0/c1 control bits and
//             infers the data-enable.
//  Ports    : clk      - pixel clock, posedge
//             rst      - asynchronous reset, active low
//             din      - 10-bit deserialized word, din[0] = first serial bit
//             bitslip  - 1-cycle request for a 1-bit deserializer shift
//             locked   - word alignment established
//             slip_cnt - bitslips in the current lock attempt, wraps 9->0
//             dout     - decoded pixel byte (valid when vld & de)
//             c0, c1   - control bits from the last control token
//             de       - 1 = data period, 0 = control period
//             vld      - decoded outputs meaningful (mirrors locked)
//             err      - invalid-symbol pulse
//             err_cnt  - saturating invalid-symbol count
//  Options  : `TMDS_RX_ERRCHK_EN enables the invalid-symbol checker; when
//             undefined err/err_cnt are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tmds_rx_decode #(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16,
  parameter int LOCK_TIMEOUT   = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  din,
  output logic        bitslip,
  output logic        locked,
  output logic [3:0]  slip_cnt,
  output logic [7:0]  dout,
  output logic        c0,
  output logic        c1,
  output logic        de,
  output logic        vld,
  output logic        err,
  output logic [15:0] err_cnt
);

  localparam int RUN_W    = $clog2(CTRL_RUN) + 1;
  localparam int TIMER_W  = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int SETTLE_W = $clog2(SLIP_WAIT) + 1;
  localparam int IDLE_W   = $clog2(LOCK_TIMEOUT) + 1;

  localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(CTRL_RUN - 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_WAIT - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SLIP   = 2'd1,
    S_SETTLE = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t              r_state;
  logic [RUN_W-1:0]    r_run;
  logic [TIMER_W-1:0]  r_timer;
  logic [SETTLE_W-1:0] r_settle;
  logic [IDLE_W-1:0]   r_idle;
  logic                r_locked;

  logic                w_is_tok;
  logic [1:0]          w_tok_c;   // {c1, c0}
  logic [7:0]          w_q;
  logic [7:0]          w_d;

  // --------------------------------------------------------------------------
  // Control token recognition
  // --------------------------------------------------------------------------
  always_comb begin
    w_is_tok = 1'b1;
    w_tok_c  = 2'b00;
    case (din)
      10'b1101010100: w_tok_c = 2'b00;
      10'b0010101011: w_tok_c = 2'b01;
      10'b0101010100: w_tok_c = 2'b10;
      10'b1010101011: w_tok_c = 2'b11;
      default:        w_is_tok = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // 10b -> 8b data decode: undo the optional inversion (din[9]), then undo
  // the XOR / XNOR transition chain selected by din[8].
  // --------------------------------------------------------------------------
  always_comb begin
    w_q    = din[9] ? ~din[7:0] : din[7:0];
    w_d    = '0;
    w_d[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      w_d[i] = din[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

  // --------------------------------------------------------------------------
  // Alignment FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_SEARCH;
      r_run    <= '0;
      r_timer  <= '0;
      r_settle <= '0;
      r_idle   <= '0;
      r_locked <= 1'b0;
      bitslip  <= 1'b0;
      slip_cnt <= 4'd0;
    end else begin
      bitslip <= 1'b0;   // one-cycle pulse only
      case (r_state)
        S_SEARCH: begin
          r_timer <= r_timer + TIMER_W'(1);
          r_run   <= w_is_tok ? r_run + RUN_W'(1) : '0;
          // A completed run takes priority over a simultaneous timer expiry.
          if (w_is_tok && (r_run == RUN_LAST)) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
            r_idle   <= '0;
            r_run    <= '0;
          end else if (r_timer == TIMER_LAST) begin
            r_state  <= S_SLIP;
            bitslip  <= 1'b1;
            slip_cnt <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
          end
        end
        S_SLIP: begin
          r_run    <= '0;
          r_timer  <= '0;
          r_settle <= '0;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          // Words arriving here may be torn by the deserializer shift.
          if (r_settle == SETTLE_LAST) begin
            r_state <= S_SEARCH;
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        S_LOCKED: begin
          if (w_is_tok) begin
            r_idle <= '0;
          end else if (r_idle == IDLE_LAST) begin
            r_state  <= S_SEARCH;
            r_locked <= 1'b0;
            r_run    <= '0;
            r_timer  <= '0;
            slip_cnt <= 4'd0;
          end else begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        default: r_state <= S_SEARCH;
      endcase
    end
  end

  assign locked = r_locked;
  assign vld    = r_locked;

  // --------------------------------------------------------------------------
  // Output pipeline: tokens update control bits, data words update dout;
  // whichever side is not updated holds its last value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 8'd0;
      c0   <= 1'b0;
      c1   <= 1'b0;
      de   <= 1'b0;
    end else if (w_is_tok) begin
      de <= 1'b0;
      c0 <= w_tok_c[0];
      c1 <= w_tok_c[1];
    end else begin
      de   <= 1'b1;
      dout <= w_d;
    end
  end

`ifdef TMDS_RX_ERRCHK_EN
  // --------------------------------------------------------------------------
  // Invalid-symbol check: re-encode the decoded byte with the transmitter's
  // q_m rule. A legal symbol reproduces exactly the received {din[8], q};
  // a mismatch means the mode bit contradicts the byte's ones count.
  // --------------------------------------------------------------------------
  logic [3:0] w_ones;
  logic       w_xnor;
  logic [8:0] w_qm;
  logic       w_bad;

  always_comb begin
    w_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_ones = w_ones + {3'b000, w_d[i]};
    end
    w_xnor  = (w_ones > 4'd4) || ((w_ones == 4'd4) && !w_d[0]);
    w_qm    = '0;
    w_qm[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ w_d[i]) : (w_qm[i-1] ^ w_d[i]);
    end
    w_qm[8] = ~w_xnor;
    w_bad   = (w_qm != {din[8], w_q});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err     <= 1'b0;
      err_cnt <= 16'd0;
    end else begin
      err <= 1'b0;
      if ((r_state == S_LOCKED) && !w_is_tok && w_bad) begin
        err <= 1'b1;
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign err     = 1'b0;
  assign err_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
